// File: rtl/rca_seq_arbiter_if.sv
// Request/response bundle for rca_seq_arbiter: two operand requesters and one result consumer.
interface rca_seq_arbiter_if #(
    parameter int W = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready
    );
endinterface

// File: rtl/rca_seq_arbiter.sv
// Two requesters time-share one 4-bit ripple-carry adder slice; W-bit sums are built
// nibble by nibble with the carry chained through a register.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        carry = c[4];
    end
endmodule

module rca_seq_arbiter #(
    parameter int W = 16
) (
    input logic          clk,
    input logic          rst_n,
    rca_seq_arbiter_if.slave bus
);
    localparam int NSLICE = W / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          last_grant;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  sum_reg;
    logic          carry_reg;
    logic          id_reg;
    logic [KW-1:0] k;

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          last_slice;
    logic [3:0]    sl_a;
    logic [3:0]    sl_b;
    logic [3:0]    sl_sum;
    logic          sl_carry;

    // On a tie the requester that did not win last time goes first.
    assign grant1     = bus.req1_valid && (!bus.req0_valid || !last_grant);
    assign grant0     = bus.req0_valid && !grant1;
    assign accept     = (state == IDLE) && (grant0 || grant1);
    assign last_slice = (k == KW'(NSLICE - 1));

    assign sl_a = op_a[{k, 2'b00} +: 4];
    assign sl_b = op_b[{k, 2'b00} +: 4];

    rca4 u_rca (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_reg),
        .sum  (sl_sum),
        .carry(sl_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = rst_n && grant0;
                bus.req1_ready = rst_n && grant1;
                if (accept) begin
                    state_nx = ADD;
                end
            end
            ADD: begin
                if (last_slice) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            id_reg     <= 1'b0;
            k          <= '0;
        end else if (accept) begin
            op_a       <= grant1 ? bus.req1_a   : bus.req0_a;
            op_b       <= grant1 ? bus.req1_b   : bus.req0_b;
            carry_reg  <= grant1 ? bus.req1_cin : bus.req0_cin;
            id_reg     <= grant1;
            last_grant <= grant1;
            k          <= '0;
        end else if (state == ADD) begin
            sum_reg[{k, 2'b00} +: 4] <= sl_sum;
            carry_reg                <= sl_carry;
            k                        <= k + 1'b1;
        end
    end

    assign bus.rsp_sum  = sum_reg;
    assign bus.rsp_cout = carry_reg;
    assign bus.rsp_id   = id_reg;
endmodule

// File: tb/tb_rca_seq_arbiter.sv
// Directed bench for rca_seq_arbiter: a per-cycle reference model checks handshakes and results,
// while directed scenarios pin literal sums, latencies and arbitration order.
module tb_rca_seq_arbiter;
    localparam int W  = 16;
    localparam int NS = W / 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_seq_arbiter_if #(.W(16)) bus ();
    rca_seq_arbiter_if #(.W(8))  bus8 ();

    rca_seq_arbiter #(.W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    rca_seq_arbiter #(.W(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one operation in flight, result due NS edges after acceptance.
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    int unsigned m_cnt  = 0;
    logic [W:0]  m_res  = '0;
    logic        m_id   = 1'b0;
    bit          p_wait0 = 1'b0, p_wait1 = 1'b0;
    logic [2*W:0] p_op0, p_op1;

    always @(negedge clk) begin
        bit w0, w1, ev;
        if (!rst_n) begin
            m_busy = 1'b0; m_last = 1'b1; m_cnt = 0;
            p_wait0 = 1'b0; p_wait1 = 1'b0;
            check("rst_req0_ready", bus.req0_ready, 0);
            check("rst_req1_ready", bus.req1_ready, 0);
            check("rst_rsp_valid",  bus.rsp_valid, 0);
            check("rst_rsp_sum",    bus.rsp_sum, 0);
            check("rst_rsp_cout",   bus.rsp_cout, 0);
            check("rst_rsp_id",     bus.rsp_id, 0);
        end else begin
            if (p_wait0 && (!bus.req0_valid || {bus.req0_a, bus.req0_b, bus.req0_cin} != p_op0)) begin
                n_err++;
                $display("FAIL hold0: requester 0 changed before ready");
            end
            if (p_wait1 && (!bus.req1_valid || {bus.req1_a, bus.req1_b, bus.req1_cin} != p_op1)) begin
                n_err++;
                $display("FAIL hold1: requester 1 changed before ready");
            end
            ev = m_busy && (m_cnt >= NS);
            w1 = bus.req1_valid && (!bus.req0_valid || !m_last);
            w0 = bus.req0_valid && !w1;
            check("req0_ready", bus.req0_ready, !m_busy && w0);
            check("req1_ready", bus.req1_ready, !m_busy && w1);
            check("rsp_valid",  bus.rsp_valid, ev);
            if (ev) begin
                check("rsp_sum",  bus.rsp_sum, m_res[W-1:0]);
                check("rsp_cout", bus.rsp_cout, m_res[W]);
                check("rsp_id",   bus.rsp_id, m_id);
            end
            p_wait0 = bus.req0_valid && !bus.req0_ready;
            p_wait1 = bus.req1_valid && !bus.req1_ready;
            p_op0   = {bus.req0_a, bus.req0_b, bus.req0_cin};
            p_op1   = {bus.req1_a, bus.req1_b, bus.req1_cin};
            if (!m_busy) begin
                if (w0 || w1) begin
                    m_busy = 1'b1; m_cnt = 0; m_last = w1; m_id = w1;
                    m_res = w1 ? ({1'b0, bus.req1_a} + {1'b0, bus.req1_b} + (W+1)'(bus.req1_cin))
                               : ({1'b0, bus.req0_a} + {1'b0, bus.req0_b} + (W+1)'(bus.req0_cin));
                end
            end else if (ev && bus.rsp_ready) begin
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
    end

    task automatic drive(input bit id, input logic [15:0] a, input logic [15:0] b, input logic c);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
        end
    endtask

    task automatic drop(input bit id);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic accept(input bit id, output int unsigned t);
        int unsigned n = 0;
        @(negedge clk);
        while (((id ? bus.req1_ready : bus.req0_ready) !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(id ? "accept1_timeout" : "accept0_timeout", n < 40, 1);
        @(posedge clk); #1;
        drop(id);
        t = cyc;
    endtask

    task automatic expect_rsp(input string name, input int unsigned t_acc, input logic [15:0] sum,
                              input logic cout, input logic id, input int unsigned lat);
        int unsigned n = 0;
        @(negedge clk);
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, cyc - t_acc, lat);
        check({name, "_sum"},  bus.rsp_sum, sum);
        check({name, "_cout"}, bus.rsp_cout, cout);
        check({name, "_id"},   bus.rsp_id, id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t, t0, t1, n;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus8.req0_valid = 1'b0; bus8.req0_a = '0; bus8.req0_b = '0; bus8.req0_cin = 1'b0;
        bus8.req1_valid = 1'b0; bus8.req1_a = '0; bus8.req1_b = '0; bus8.req1_cin = 1'b0;
        bus8.rsp_ready  = 1'b1;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Carry-in only
        drive(0, 16'h0000, 16'h0009, 1'b1);
        accept(0, t);
        expect_rsp("cin_only", t, 16'h000A, 1'b0, 1'b0, 4);
        @(posedge clk); #1;
        check("cin_only_valid_drop", bus.rsp_valid, 0);

        // Full ripple across all slices
        drive(1, 16'hFFFF, 16'h0000, 1'b1);
        accept(1, t);
        expect_rsp("ripple", t, 16'h0000, 1'b1, 1'b1, 4);
        @(posedge clk); #1;

        // Tie, then the loser follows with full throughput
        drive(0, 16'h3333, 16'hCCCC, 1'b0);
        drive(1, 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        check("tie_a_ready0", bus.req0_ready, 1);
        check("tie_a_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        drop(0);
        t0 = cyc;
        expect_rsp("tie_a0", t0, 16'hFFFF, 1'b0, 1'b0, 4);
        accept(1, t1);
        check("throughput", t1 - t0, NS + 2);
        expect_rsp("tie_a1", t1, 16'hFFFF, 1'b1, 1'b1, 4);
        @(posedge clk); #1;

        // Further tie goes to requester 0
        drive(0, 16'h1111, 16'h2222, 1'b0);
        drive(1, 16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        check("tie_b_ready0", bus.req0_ready, 1);
        check("tie_b_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        drop(0);
        t = cyc;
        expect_rsp("tie_b0", t, 16'h3333, 1'b0, 1'b0, 4);
        accept(1, t);
        expect_rsp("tie_b1", t, 16'h0002, 1'b0, 1'b1, 4);
        @(posedge clk); #1;

        // Backpressure with a new request arriving during RESP
        bus.rsp_ready = 1'b0;
        drive(0, 16'h1234, 16'h4321, 1'b1);
        accept(0, t);
        expect_rsp("bp", t, 16'h5556, 1'b0, 1'b0, 4);
        @(posedge clk); #1;
        drive(1, 16'h0100, 16'h0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid",  bus.rsp_valid, 1);
            check("bp_hold_sum",    bus.rsp_sum, 16'h5556);
            check("bp_hold_ready1", bus.req1_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        check("bp_release_valid", bus.rsp_valid, 0);
        accept(1, t);
        expect_rsp("bp_next", t, 16'h0200, 1'b0, 1'b1, 4);
        @(posedge clk); #1;

        // Reset during the second ADD cycle
        drive(1, 16'h12FF, 16'h0001, 1'b0);
        accept(1, t);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 16'h0005, 16'h0005, 1'b0);
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_rsp_sum",   bus.rsp_sum, 0);
        check("midrst_rsp_cout",  bus.rsp_cout, 0);
        check("midrst_rsp_id",    bus.rsp_id, 0);
        check("midrst_ready0",    bus.req0_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        drop(0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) n++;
        end
        check("midrst_no_response", n, 0);
        @(posedge clk); #1;
        drive(0, 16'h00FF, 16'h0001, 1'b0);
        accept(0, t);
        expect_rsp("post_rst", t, 16'h0100, 1'b0, 1'b0, 4);
        @(posedge clk); #1;

        // W=8 instance: two slices
        bus8.req0_valid = 1'b1; bus8.req0_a = 8'hF0; bus8.req0_b = 8'h10; bus8.req0_cin = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus8.req0_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w8_accept_timeout", n < 40, 1);
        @(posedge clk); #1;
        bus8.req0_valid = 1'b0;
        t = cyc;
        n = 0;
        @(negedge clk);
        while (bus8.rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w8_latency", cyc - t, 2);
        check("w8_sum",  bus8.rsp_sum, 8'h00);
        check("w8_cout", bus8.rsp_cout, 1);
        check("w8_id",   bus8.rsp_id, 0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rca_seq_arbiter.md
# rca_seq_arbiter

Shared-adder sequencer that lets two requesters time-share a single 4-bit ripple-carry adder (RCA) slice to perform W-bit additions. A round-robin arbiter accepts one operation at a time, and a slice counter walks the operands through the RCA least-significant nibble first, chaining the carry through a register. The result is returned on a valid/ready response port. The block sits between the operand producers and the 4-bit RCA, and is the only user of that RCA.

## Interface
- W, default 16: operand/result width; must be a multiple of 4 and at least 4. NSLICE = W/4 (derived).
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- req0_valid, in, 1: requester 0 has an operation.
- req0_ready, out, 1: requester 0 operation accepted this cycle when high together with req0_valid.
- req0_a, in, W: addend A.
- req0_b, in, W: addend B.
- req0_cin, in, 1: carry-in.
- req1_valid / req1_ready / req1_a / req1_b / req1_cin: same as requester 0, for requester 1.
- rsp_valid, out, 1: result available.
- rsp_ready, in, 1: consumer takes the result.
- rsp_id, out, 1: index of the requester that issued the operation.
- rsp_sum, out, W: sum.
- rsp_cout, out, 1: final carry-out.

## Operation
- The datapath is one instantiated 4-bit RCA (a, b, cin, sum, carry). No other adder is permitted.
- FSM states are IDLE, ADD and RESP.
- **IDLE**
  - Winner: if only one requester is valid, it wins. If both are valid, the winner is the one not granted last time.
  - The last_grant register resets to 1, so req0 wins the first tie.
  - reqX_ready = (state==IDLE) && (X is the winner). Readies are combinational from the valids and state.
  - On valid&&ready: capture a, b, cin and id into internal registers; clear the slice index k to 0; update last_grant; go to ADD.
- **ADD** (one slice per cycle, NSLICE cycles)
  - The RCA gets op_a[4k+3:4k], op_b[4k+3:4k] and the carry register.
  - Its sum is written to sum_reg[4k+3:4k]; its carry is written to the carry register; k increments.
  - After slice NSLICE-1: go to RESP.
- **RESP**
  - rsp_valid=1. rsp_sum = sum_reg, rsp_cout = carry register, rsp_id = captured id.
  - On rsp_valid&&rsp_ready: go to IDLE.
- Arithmetic is modulo 2^W. rsp_cout is bit W of a + b + cin.
- Both readies are 0 in ADD and RESP. No operation is queued.
- Requesters must hold valid and operands stable until ready. The bench flags any violation.
- rsp_sum, rsp_cout and rsp_id stay stable while rsp_valid && !rsp_ready.

## Timing
- **Reset values** (immediate on rst_n low, independent of clk):
  - state=IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, last_grant=1, k=0, carry register=0.
  - req0_ready=req1_ready=0 while rst_n is low.
- **Latency**: accept at edge E, then rsp_valid rises at edge E+NSLICE (4 cycles for W=16).
- **Throughput**: with rsp_ready held high, one operation every NSLICE+2 cycles. The RESP handshake edge returns to IDLE, and the next accept occurs one edge later.
- **Response handshake**: rsp_valid falls on the edge after the rsp_valid&&rsp_ready cycle.
- **Reset mid-operation** (ADD or RESP): the in-flight operation is discarded with no response, and all outputs take their reset values.
- **New valid during ADD/RESP**: not accepted. It is arbitrated on return to IDLE.
- **Simultaneous RESP handshake and a new request valid**: the request is not accepted in that cycle. Acceptance happens in the following IDLE cycle.

## Test plan
- **Single op, carry-in only**: req0 a=0x0000, b=0x0009, cin=1, W=16 -> rsp_sum=0x000A, rsp_cout=0, rsp_id=0, rsp_valid exactly 4 cycles after accept.
- **Full carry ripple across slices**: req1 a=0xFFFF, b=0x0000, cin=1 -> rsp_sum=0x0000, rsp_cout=1, rsp_id=1.
- **Tie after reset, then tie again**:
  - req0 (0x3333+0xCCCC, cin=0) and req1 (0xFFFF+0xFFFF, cin=1) both valid.
  - Required order: req0 first (0xFFFF, cout=0), then req1 (0xFFFF, cout=1).
  - A further tie grants req0.
- **Backpressure**: rsp_ready=0 for 5 cycles in RESP -> outputs held stable, both readies 0, no accept. rsp_ready=1 -> IDLE on the next edge.
- **Reset mid-ADD**:
  - Assert rst_n low during the 2nd ADD cycle -> rsp_valid=0 and all outputs at reset values at once, no response.
  - After release, req0 0x00FF+0x0001 -> 0x0100, cout=0.
- **W=8**: a=0xF0, b=0x10, cin=0 -> rsp_sum=0x00, rsp_cout=1, latency 2 cycles.
